// File: rtl/uart_imem_loader_pkg.sv
// uart_loader_pkg: shared types and constants for the UART instruction-memory loader.
//   ldr_state_e   - loader FSM states
//   LDR_HDR/ACK/NAK - frame header byte and response bytes
//   ldr_tmo_state - states in which the inter-byte timeout runs
package uart_loader_pkg;

  typedef enum logic [3:0] {
    IDLE,
    HDR,
    LEN0,
    LEN1,
    DATA,
    WRITE,
    CSUM,
    RESP,
    DONE
  } ldr_state_e;

  localparam logic [7:0] LDR_HDR = 8'hA5;
  localparam logic [7:0] LDR_ACK = 8'h06;
  localparam logic [7:0] LDR_NAK = 8'h15;

  // Inside a frame the host must keep bytes coming; HDR may wait forever.
  function automatic logic ldr_tmo_state(ldr_state_e s);
    return (s == LEN0) || (s == LEN1) || (s == DATA) || (s == CSUM);
  endfunction

  function automatic logic ldr_rd_state(ldr_state_e s);
    return (s == HDR) || ldr_tmo_state(s);
  endfunction

endpackage

// File: rtl/uart_imem_loader_if.sv
// uart_imem_loader_if: UART MMIO port group plus imem programming port.
//   master - the loader (pops RX, pushes TX, writes imem)
//   slave  - the UART / imem side
interface uart_imem_loader_if;
  logic        rx_data_present;
  logic [7:0]  uart_dout;
  logic        tx_full;
  logic        rx_ren;
  logic        tx_wen;
  logic [7:0]  uart_din;
  logic [2:0]  uart_addr;
  logic        imem_en;
  logic        imem_prog_ena;
  logic [31:0] imem_addr;
  logic [31:0] imem_din;

  modport master (
    input  rx_data_present, uart_dout, tx_full,
    output rx_ren, tx_wen, uart_din, uart_addr,
           imem_en, imem_prog_ena, imem_addr, imem_din
  );

  modport slave (
    output rx_data_present, uart_dout, tx_full,
    input  rx_ren, tx_wen, uart_din, uart_addr,
           imem_en, imem_prog_ena, imem_addr, imem_din
  );
endinterface

// File: rtl/uart_imem_loader_byte_reader.sv
// uart_byte_reader: fetches single bytes from the UART RX FIFO on request.
//   req/rx_data_present -> rx_ren  : one-cycle pop strobe (registered)
//   uart_dout           -> byte_data: captured the cycle after rx_ren
//   byte_valid          : one-cycle pulse, byte_data valid
//   tmo_en/timeout      : idle counter, cleared on every captured byte
//   flush               : drops any fetch in flight
module uart_byte_reader #(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       req,
  input  logic       tmo_en,
  input  logic       rx_data_present,
  input  logic [7:0] uart_dout,
  output logic       rx_ren,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       timeout
);

  localparam int STAGES = 2;
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  // [0] pop strobe, [1] uart_dout valid, [2] captured byte valid
  logic [STAGES:0] vld_pipe_q, vld_pipe_d;
  logic [7:0]      data_q, data_d;
  logic [31:0]     cnt_q, cnt_d;
  logic            issue;

  // Only one fetch in flight: rx_data_present is stale until the pop has
  // been seen by the FIFO, and this also rules out back-to-back pops.
  assign issue = req && rx_data_present && !flush && (vld_pipe_q == '0);

  always_comb begin
    vld_pipe_d = {vld_pipe_q[STAGES-1:0], issue};
    if (flush) vld_pipe_d = '0;
    data_d = vld_pipe_q[1] ? uart_dout : data_q;
    cnt_d  = cnt_q;
    if (!tmo_en || vld_pipe_q[STAGES]) cnt_d = '0;
    else if (cnt_q != TMO_LAST)        cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
    end
  end

  assign rx_ren     = vld_pipe_q[0];
  assign byte_valid = vld_pipe_q[STAGES];
  assign byte_data  = data_q;
  assign timeout    = tmo_en && (cnt_q == TMO_LAST);

endmodule

// File: rtl/uart_imem_loader.sv
// uart_imem_loader: serial bootloader. Frames bytes A5, LEN_LO, LEN_HI,
// LEN x 4 payload bytes (little-endian words), XOR checksum, writes words
// into imem and answers ACK (06) or NAK (15) through the UART TX FIFO.
//   clk, Rst         - clock, synchronous active-high reset
//   prog             - loader enable; falling edge aborts to IDLE
//   bus (master)     - UART RX/TX and imem programming port
//   busy             - not in IDLE
//   done             - one-cycle pulse after an ACK has been pushed
//   err              - sticky, cleared when the next header is accepted
//   words_written    - words written in the current/last frame
module uart_imem_loader
  import uart_loader_pkg::*;
#(
  parameter int unsigned IMEM_WORDS     = 4096,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter logic [2:0]  UART_DATA_ADDR = 3'd0
) (
  input  logic                 clk,
  input  logic                 Rst,
  input  logic                 prog,
  uart_imem_loader_if.master   bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [15:0]          words_written
);

  localparam logic [31:0] MAX_WORDS = 32'(IMEM_WORDS);

  ldr_state_e  state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [7:0]  csum_q, csum_d;
  logic [15:0] ww_q, ww_d;
  logic        err_q, err_d;
  logic [7:0]  resp_q, resp_d;
  logic        tx_wen_q, tx_wen_d;
  logic [7:0]  uart_din_q, uart_din_d;
  logic        imem_we_q, imem_we_d;
  logic [31:0] imem_addr_q, imem_addr_d;
  logic [31:0] imem_din_q, imem_din_d;
  logic        done_q, done_d;

  logic        byte_valid, timeout;
  logic [7:0]  byte_data;
  logic [15:0] len_full;

  uart_byte_reader #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rd (
    .clk             (clk),
    .rst             (Rst),
    .flush           (!prog),
    .req             (ldr_rd_state(state_q)),
    .tmo_en          (ldr_tmo_state(state_q)),
    .rx_data_present (bus.rx_data_present),
    .uart_dout       (bus.uart_dout),
    .rx_ren          (bus.rx_ren),
    .byte_valid      (byte_valid),
    .byte_data       (byte_data),
    .timeout         (timeout)
  );

  assign len_full = {byte_data, len_q[7:0]};

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    word_d      = word_q;
    bcnt_d      = bcnt_q;
    csum_d      = csum_q;
    ww_d        = ww_q;
    err_d       = err_q;
    resp_d      = resp_q;
    tx_wen_d    = 1'b0;
    uart_din_d  = uart_din_q;
    imem_we_d   = 1'b0;
    imem_addr_d = imem_addr_q;
    imem_din_d  = imem_din_q;
    done_d      = 1'b0;

    // prog low beats timeout, timeout beats byte capture
    if (!prog) begin
      state_d = IDLE;
      if (!(state_q inside {IDLE, HDR, DONE})) err_d = 1'b1;
    end else if (timeout) begin
      state_d = HDR;
      err_d   = 1'b1;
    end else begin
      case (state_q)
        IDLE: state_d = HDR;
        HDR: if (byte_valid && byte_data == LDR_HDR) begin
          state_d = LEN0;
          err_d   = 1'b0;
          ww_d    = '0;
          csum_d  = '0;
        end
        LEN0: if (byte_valid) begin
          len_d[7:0] = byte_data;
          state_d    = LEN1;
        end
        LEN1: if (byte_valid) begin
          len_d  = len_full;
          bcnt_d = '0;
          if ({16'd0, len_full} > MAX_WORDS) begin
            resp_d  = LDR_NAK;
            err_d   = 1'b1;
            state_d = RESP;
          end else if (len_full == 16'd0) begin
            state_d = CSUM;
          end else begin
            state_d = DATA;
          end
        end
        DATA: if (byte_valid) begin
          // shift in from the top: after four bytes byte 0 sits in [7:0]
          word_d = {byte_data, word_q[31:8]};
          csum_d = csum_q ^ byte_data;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            state_d     = WRITE;
            imem_we_d   = 1'b1;
            imem_addr_d = BASE_ADDR + {14'd0, ww_q, 2'b00};
            imem_din_d  = word_d;
          end
        end
        WRITE: begin
          ww_d    = ww_q + 16'd1;
          state_d = (ww_d == len_q) ? CSUM : DATA;
        end
        CSUM: if (byte_valid) begin
          state_d = RESP;
          if (byte_data == csum_q) resp_d = LDR_ACK;
          else begin
            resp_d = LDR_NAK;
            err_d  = 1'b1;
          end
        end
        RESP: if (!bus.tx_full) begin
          tx_wen_d   = 1'b1;
          uart_din_d = resp_q;
          state_d    = (resp_q == LDR_ACK) ? DONE : HDR;
        end
        DONE: begin
          done_d  = 1'b1;
          state_d = HDR;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      word_q      <= '0;
      bcnt_q      <= '0;
      csum_q      <= '0;
      ww_q        <= '0;
      err_q       <= 1'b0;
      resp_q      <= '0;
      tx_wen_q    <= 1'b0;
      uart_din_q  <= '0;
      imem_we_q   <= 1'b0;
      imem_addr_q <= '0;
      imem_din_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      word_q      <= word_d;
      bcnt_q      <= bcnt_d;
      csum_q      <= csum_d;
      ww_q        <= ww_d;
      err_q       <= err_d;
      resp_q      <= resp_d;
      tx_wen_q    <= tx_wen_d;
      uart_din_q  <= uart_din_d;
      imem_we_q   <= imem_we_d;
      imem_addr_q <= imem_addr_d;
      imem_din_q  <= imem_din_d;
      done_q      <= done_d;
    end
  end

  assign bus.tx_wen        = tx_wen_q;
  assign bus.uart_din      = uart_din_q;
  assign bus.uart_addr     = UART_DATA_ADDR;
  assign bus.imem_en       = imem_we_q;
  assign bus.imem_prog_ena = imem_we_q;
  assign bus.imem_addr     = imem_addr_q;
  assign bus.imem_din      = imem_din_q;

  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign err           = err_q;
  assign words_written = ww_q;

endmodule
